// File: rtl/popcount_pkg.sv
// Shared constants, count type and transmitter FSM states for the popcount24 family.
package popcount_pkg;

    localparam int POPCNT_N = 24;
    localparam int POPCNT_W = 5;

    typedef logic [POPCNT_W-1:0] cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/popcount_unary_tx.sv
// Serializes a population count into an N_BITS-beat unary (thermometer) word,
// one bit per cycle on a valid/ready stream.
module popcount_unary_tx
    import popcount_pkg::*;
#(
    parameter int N_BITS      = POPCNT_N,
    parameter int CNT_W       = POPCNT_W,
    parameter bit ZEROS_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cnt_valid_i,
    output logic             cnt_ready_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             bit_last_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] ones_sent_o
);

    localparam int               IDX_W    = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);

    // Handshake: a count moves on cnt_valid_i & cnt_ready_o, a beat on
    // bit_valid_o & bit_ready_i; a raised bit_valid_o is held until taken.
    tx_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic             sat_q, sat_d;

    logic             emit;
    logic             therm_bit;
    logic             in_sat;
    logic [CNT_W-1:0] idx_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_lat_q <= '0;
            ones_q    <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_lat_q <= cnt_lat_d;
            ones_q    <= ones_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        emit    = (state_q == EMIT);
        idx_ext = CNT_W'(idx_q);
        in_sat  = (cnt_i > N_CNT);

        // cnt_lat_q never exceeds N_CNT, so the subtraction cannot underflow.
        if (ZEROS_FIRST) begin
            therm_bit = (idx_ext >= (N_CNT - cnt_lat_q));
        end else begin
            therm_bit = (idx_ext < cnt_lat_q);
        end

        // Outputs depend on registered state only.
        cnt_ready_o = ~emit;
        bit_valid_o = emit;
        bit_o       = emit & therm_bit;
        bit_last_o  = emit & (idx_q == IDX_LAST);
        sat_o       = sat_q;
        ones_sent_o = ones_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_lat_d = cnt_lat_q;
        ones_d    = ones_q;
        sat_d     = sat_q;

        case (state_q)
            IDLE: begin
                if (cnt_valid_i) begin
                    state_d   = EMIT;
                    idx_d     = '0;
                    ones_d    = '0;
                    sat_d     = in_sat;
                    cnt_lat_d = in_sat ? N_CNT : cnt_i;
                end
            end
            EMIT: begin
                if (bit_ready_i) begin
                    ones_d = ones_q + CNT_W'(therm_bit);
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_popcount_unary_tx.sv
// Bench for popcount_unary_tx: both ZEROS_FIRST variants share one stimulus stream
// and are checked beat by beat against thermometer words built from the count.
module tb_popcount_unary_tx;
    import popcount_pkg::*;

    localparam int N = POPCNT_N;

    logic          clk = 1'b0;
    logic          rst;
    cnt_t          cnt_i;
    logic          cnt_valid_i;
    logic          bit_ready_i;

    logic          cnt_ready0, bit0, valid0, last0, sat0;
    cnt_t          ones0;
    logic          cnt_ready1, bit1, valid1, last1, sat1;
    cnt_t          ones1;

    int            pass_cnt  = 0;
    int            total_cnt = 0;

    always #5 clk = ~clk;

    popcount_unary_tx #(.ZEROS_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cnt_i(cnt_i), .cnt_valid_i(cnt_valid_i),
        .cnt_ready_o(cnt_ready0), .bit_o(bit0), .bit_valid_o(valid0),
        .bit_ready_i(bit_ready_i), .bit_last_o(last0), .sat_o(sat0),
        .ones_sent_o(ones0)
    );

    popcount_unary_tx #(.ZEROS_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cnt_i(cnt_i), .cnt_valid_i(cnt_valid_i),
        .cnt_ready_o(cnt_ready1), .bit_o(bit1), .bit_valid_o(valid1),
        .bit_ready_i(bit_ready_i), .bit_last_o(last1), .sat_o(sat1),
        .ones_sent_o(ones1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready0"}, cnt_ready0, 1);
        chk({tag, "_ready1"}, cnt_ready1, 1);
        chk({tag, "_bit0"},   bit0,       0);
        chk({tag, "_bit1"},   bit1,       0);
        chk({tag, "_valid0"}, valid0,     0);
        chk({tag, "_valid1"}, valid1,     0);
        chk({tag, "_last0"},  last0,      0);
        chk({tag, "_last1"},  last1,      0);
        chk({tag, "_sat0"},   sat0,       0);
        chk({tag, "_sat1"},   sat1,       0);
        chk({tag, "_ones0"},  ones0,      0);
        chk({tag, "_ones1"},  ones1,      0);
    endtask

    // Called and returns at a falling edge. abort_beat < 0 runs the word to the end.
    task automatic run_word(input int c, input int stall_pct, input int abort_beat);
        logic [0:0] exp_q0[$];
        logic [0:0] exp_q1[$];
        int clamp, beat, cycles, ones_e0, ones_e1;
        logic go;

        clamp = (c > N) ? N : c;
        for (int k = 0; k < N; k++) begin
            exp_q0.push_back(1'(k < clamp));
            exp_q1.push_back(1'(k >= N - clamp));
        end

        chk("ready_before_accept0", cnt_ready0, 1);
        chk("ready_before_accept1", cnt_ready1, 1);
        cnt_i       = c[POPCNT_W-1:0];
        cnt_valid_i = 1'b1;
        bit_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);

        cycles  = 1;
        beat    = 0;
        ones_e0 = 0;
        ones_e1 = 0;
        while (exp_q0.size() > 0 && cycles < 400) begin
            chk("valid0", valid0, 1);
            chk("valid1", valid1, 1);
            chk("bit_zf0", bit0, exp_q0[0]);
            chk("bit_zf1", bit1, exp_q1[0]);
            chk("last0", last0, exp_q0.size() == 1);
            chk("last1", last1, exp_q1.size() == 1);
            chk("ones_sent0", ones0, ones_e0);
            chk("ones_sent1", ones1, ones_e1);
            chk("ready_emit0", cnt_ready0, 0);
            chk("sat_emit0", sat0, c > N);
            chk("sat_emit1", sat1, c > N);

            if (beat == abort_beat) begin
                bit_ready_i = 1'b1;
                cnt_valid_i = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset("async_rst");
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check_reset("after_rst");
                return;
            end

            // Offers during a word must be ignored.
            cnt_valid_i = 1'($urandom_range(0, 1));
            cnt_i       = cnt_t'($urandom_range(0, 31));
            go          = ($urandom_range(0, 99) >= stall_pct);
            bit_ready_i = go;
            @(negedge clk);
            cycles++;
            if (go) begin
                ones_e0 += int'(exp_q0.pop_front());
                ones_e1 += int'(exp_q1.pop_front());
                beat++;
            end
        end

        cnt_valid_i = 1'b0;
        chk("word_complete", exp_q0.size(), 0);
        chk("idle_ready0", cnt_ready0, 1);
        chk("idle_ready1", cnt_ready1, 1);
        chk("idle_valid0", valid0, 0);
        chk("idle_valid1", valid1, 0);
        chk("idle_bit0", bit0, 0);
        chk("idle_last0", last0, 0);
        chk("final_ones0", ones0, clamp);
        chk("final_ones1", ones1, clamp);
        chk("final_sat0", sat0, c > N);
        chk("final_sat1", sat1, c > N);
        if (stall_pct == 0) chk("word_period", cycles, N + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cnt_i       = '0;
        cnt_valid_i = 1'b0;
        bit_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        run_word(7, 0, -1);
        run_word(0, 0, -1);
        run_word(24, 0, -1);
        run_word(31, 0, -1);
        run_word(3, 0, -1);
        run_word(5, 50, -1);
        run_word(10, 0, -1);
        run_word(20, 0, 12);
        run_word(2, 0, -1);
        run_word(25, 30, -1);
        for (int w = 0; w < 8; w++) begin
            run_word(int'($urandom_range(0, 31)), int'($urandom_range(0, 60)), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
